// File: rtl/mpmc11_cache_ctrl_pkg.sv
// mpmc11_pkg: shared types and constants for the mpmc11 line cache.
//   state_t      controller states
//   CMD_READ/    encoding of the request write-enable
//   CMD_WRITE
//   DEF_*        default geometry
package mpmc11_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_FILL,
        ST_RESPOND
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int DEF_WAYS      = 4;
    localparam int DEF_SETS      = 256;
    localparam int DEF_LINE_BITS = 128;
    localparam int DEF_AMSB      = 28;

endpackage

// File: rtl/mpmc11_cache_ram.sv
// mpmc11_cache_ram: simple dual-port RAM, one write port, one synchronous read
// port (read-before-write on address collision).
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, data appears on o_rdata after the next clock
//   o_rdata  registered read data
module mpmc11_cache_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mpmc11_cache_ctrl.sv
// mpmc11_cache_ctrl: N-way set-associative write-back, write-allocate line
// cache between the port arbiter and the DRAM command sequencer.
//   clk, rst            clock, asynchronous active-high reset
//   i_req/i_inv         request / invalidate, accepted while o_req_rdy=1
//   i_req_we/_adr/_sel/_dat  command, byte address, byte enables, write data
//   o_resp_v/_hit/_dat  one-cycle response strobe, hit flag, full line
//   o_mem_req/_we/_adr/_dat  memory cycle (held until i_mem_ack)
//   i_mem_ack/i_mem_dat      memory completion strobe and fill data
module mpmc11_cache_ctrl
    import mpmc11_pkg::*;
#(
    parameter int WAYS      = DEF_WAYS,
    parameter int SETS      = DEF_SETS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int AMSB      = DEF_AMSB
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req,
    input  logic                   i_req_we,
    input  logic [AMSB:0]          i_req_adr,
    input  logic [LINE_BITS/8-1:0] i_req_sel,
    input  logic [LINE_BITS-1:0]   i_req_dat,
    input  logic                   i_inv,
    output logic                   o_req_rdy,
    output logic                   o_resp_v,
    output logic                   o_resp_hit,
    output logic [LINE_BITS-1:0]   o_resp_dat,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [AMSB:0]          o_mem_adr,
    output logic [LINE_BITS-1:0]   o_mem_dat,
    input  logic                   i_mem_ack,
    input  logic [LINE_BITS-1:0]   i_mem_dat
);

    localparam int NB    = LINE_BITS / 8;
    localparam int OFS   = $clog2(NB);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = AMSB + 1 - OFS - IDX;
    localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int MW    = TAG_W + 2;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic                 modified;
        logic                 valid;
        logic [LINE_BITS-1:0] data;
    } line_t;

    function automatic logic [LINE_BITS-1:0] merge(input logic [LINE_BITS-1:0] base,
                                                   input logic [LINE_BITS-1:0] wr,
                                                   input logic [NB-1:0]        sel);
        merge = base;
        for (int unsigned b = 0; b < NB; b++)
            if (sel[b]) merge[8*b +: 8] = wr[8*b +: 8];
    endfunction

    state_t               r_state;
    logic [IDX-1:0]       r_clr, r_idx;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_we, r_inv;
    logic [NB-1:0]        r_sel;
    logic [LINE_BITS-1:0] r_dat;
    logic [WB-1:0]        r_way;
    logic [WB-1:0]        r_ptr [SETS];
    logic                 r_rdy, r_resp_v, r_resp_hit, r_mem_req, r_mem_we;
    logic [LINE_BITS-1:0] r_resp_dat, r_mem_dat;
    logic [AMSB:0]        r_mem_adr;

    logic [MW-1:0]        w_meta_q [WAYS];
    logic [LINE_BITS-1:0] w_dat_q  [WAYS];
    line_t                w_line   [WAYS];
    logic [WAYS-1:0]      w_hit_vec, w_meta_we, w_dat_we;
    logic                 w_hit, w_has_free;
    logic [WB-1:0]        w_hit_way, w_free_way, w_vict;
    line_t                w_hit_line, w_vict_line, w_wr_line;
    logic [LINE_BITS-1:0] w_hit_merged, w_fill_merged;
    logic [IDX-1:0]       w_rd_idx, w_wr_idx;
    logic                 w_unused_ofs;

    assign w_unused_ofs = ^i_req_adr[OFS-1:0];

    // In IDLE the arrays are addressed straight from the request so the set
    // is already on the RAM outputs when LOOKUP starts.
    assign w_rd_idx = (r_state == ST_IDLE) ? i_req_adr[OFS +: IDX] : r_idx;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        mpmc11_cache_ram #(.DW(MW), .DEPTH(SETS)) u_meta (
            .clk     (clk),
            .i_we    (w_meta_we[g]),
            .i_waddr (w_wr_idx),
            .i_wdata (w_wr_line[LINE_BITS +: MW]),
            .i_raddr (w_rd_idx),
            .o_rdata (w_meta_q[g])
        );
        mpmc11_cache_ram #(.DW(LINE_BITS), .DEPTH(SETS)) u_data (
            .clk     (clk),
            .i_we    (w_dat_we[g]),
            .i_waddr (w_wr_idx),
            .i_wdata (w_wr_line.data),
            .i_raddr (w_rd_idx),
            .o_rdata (w_dat_q[g])
        );
        assign w_line[g] = {w_meta_q[g], w_dat_q[g]};
    end

    always_comb begin
        w_hit_vec  = '0;
        w_hit_way  = '0;
        w_free_way = '0;
        w_has_free = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = w_line[w].valid && (w_line[w].tag == r_tag);
            if (w_hit_vec[w]) w_hit_way = WB'(w);
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!w_line[w-1].valid) begin
                w_free_way = WB'(w - 1);
                w_has_free = 1'b1;
            end
        end
    end

    assign w_hit         = |w_hit_vec;
    assign w_hit_line    = w_line[w_hit_way];
    assign w_vict        = w_has_free ? w_free_way : r_ptr[r_idx];
    assign w_vict_line   = w_line[w_vict];
    assign w_hit_merged  = merge(w_hit_line.data, r_dat, r_sel);
    assign w_fill_merged = merge(i_mem_dat, r_dat, r_we ? r_sel : '0);

    always_comb begin
        w_meta_we = '0;
        w_dat_we  = '0;
        w_wr_idx  = r_idx;
        w_wr_line = '0;
        case (r_state)
            ST_CLEAR: begin
                w_meta_we = '1;
                w_wr_idx  = r_clr;
            end
            ST_LOOKUP: begin
                if (r_inv) begin
                    // Clean hit is dropped here; a dirty hit is dropped after writeback.
                    if (w_hit && !w_hit_line.modified) w_meta_we[w_hit_way] = 1'b1;
                end else if (w_hit && r_we) begin
                    w_meta_we[w_hit_way] = 1'b1;
                    w_dat_we[w_hit_way]  = 1'b1;
                    w_wr_line = '{tag: r_tag, modified: 1'b1, valid: 1'b1, data: w_hit_merged};
                end
            end
            ST_EVICT: begin
                if (i_mem_ack && r_inv) w_meta_we[r_way] = 1'b1;
            end
            ST_FILL: begin
                if (i_mem_ack) begin
                    w_meta_we[r_way] = 1'b1;
                    w_dat_we[r_way]  = 1'b1;
                    w_wr_line = '{tag: r_tag, modified: r_we, valid: 1'b1, data: w_fill_merged};
                end
            end
            default: ;
        endcase
    end

    // Round-robin pointers advance only when every way of the set is valid.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR)
            r_ptr[r_clr] <= '0;
        else if (r_state == ST_LOOKUP && !r_inv && !w_hit && !w_has_free)
            r_ptr[r_idx] <= (r_ptr[r_idx] == WB'(WAYS - 1)) ? '0 : r_ptr[r_idx] + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr      <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_we       <= 1'b0;
            r_inv      <= 1'b0;
            r_sel      <= '0;
            r_dat      <= '0;
            r_way      <= '0;
            r_rdy      <= 1'b0;
            r_resp_v   <= 1'b0;
            r_resp_hit <= 1'b0;
            r_resp_dat <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_adr  <= '0;
            r_mem_dat  <= '0;
        end else begin
            r_resp_v <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clr <= r_clr + 1'b1;
                    if (r_clr == IDX'(SETS - 1)) begin
                        r_state <= ST_IDLE;
                        r_rdy   <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_inv || i_req) begin
                        r_inv   <= i_inv;
                        r_we    <= (i_req_we == CMD_WRITE) && !i_inv;
                        r_tag   <= i_req_adr[AMSB -: TAG_W];
                        r_idx   <= i_req_adr[OFS +: IDX];
                        r_sel   <= i_req_sel;
                        r_dat   <= i_req_dat;
                        r_rdy   <= 1'b0;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (r_inv && w_hit && w_hit_line.modified) begin
                        r_way     <= w_hit_way;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_mem_adr <= {r_tag, r_idx, {OFS{1'b0}}};
                        r_mem_dat <= w_hit_line.data;
                        r_state   <= ST_EVICT;
                    end else if (r_inv || w_hit) begin
                        r_resp_v   <= 1'b1;
                        r_resp_hit <= w_hit;
                        r_resp_dat <= r_we ? w_hit_merged : w_hit_line.data;
                        r_rdy      <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_way     <= w_vict;
                        r_mem_req <= 1'b1;
                        r_mem_dat <= w_vict_line.data;
                        if (w_vict_line.valid && w_vict_line.modified) begin
                            r_mem_we  <= 1'b1;
                            r_mem_adr <= {w_vict_line.tag, r_idx, {OFS{1'b0}}};
                            r_state   <= ST_EVICT;
                        end else begin
                            r_mem_we  <= 1'b0;
                            r_mem_adr <= {r_tag, r_idx, {OFS{1'b0}}};
                            r_state   <= ST_FILL;
                        end
                    end
                end
                ST_EVICT: begin
                    if (i_mem_ack) begin
                        if (r_inv) begin
                            r_mem_req  <= 1'b0;
                            r_resp_v   <= 1'b1;
                            r_resp_hit <= 1'b1;
                            r_resp_dat <= r_mem_dat;
                            r_rdy      <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_mem_we  <= 1'b0;
                            r_mem_adr <= {r_tag, r_idx, {OFS{1'b0}}};
                            r_state   <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (i_mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_resp_dat <= w_fill_merged;
                        r_state    <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    r_resp_v   <= 1'b1;
                    r_resp_hit <= 1'b0;
                    r_rdy      <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_rdy  = r_rdy;
    assign o_resp_v   = r_resp_v;
    assign o_resp_hit = r_resp_hit;
    assign o_resp_dat = r_resp_dat;
    assign o_mem_req  = r_mem_req;
    assign o_mem_we   = r_mem_we;
    assign o_mem_adr  = r_mem_adr;
    assign o_mem_dat  = r_mem_dat;

endmodule
